dbg_bus_master: RTL and testbench
=================================

# dbg_bus_master

Bus-master sequencer that lets the debug unit issue single and burst read/write transactions on the shared system bus. It sits between the debug-side command/data streams (already in the system-clock domain) and the `*OUT`/`*IN` bus signals of the JTAG debug interface. It requests the bus, runs the begin/data/end handshake, enforces flow control in both directions, and reports completion or error.

## Interface
- `TIMEOUT_CYCLES`, 1024: idle cycles allowed between bus events before the transfer is aborted; minimum 2.
- `system_clock`  in  1  sole clock; everything rises on this edge.
- `system_reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`, `req_ready`  in/out  1  command handshake; transfer occurs when both are high.
- `req_write`  in  1  1 = write, 0 = read.
- `req_address`  in  32  start address.
- `req_byte_en`  in  4  byte enables.
- `req_burst`  in  8  beats minus one (0 = single word, 255 = 256 words).
- `wr_data`, `wr_valid`, `wr_ready`  in/in/out  32/1/1  write-data stream.
- `rd_data`, `rd_valid`, `rd_ready`  out/out/in  32/1/1  read-data stream.
- `done_o`, `done_error_o`  out  1  one-cycle completion pulse and its error flag.
- `bus_request_o`, `bus_grant_i`  out/in  1  arbiter handshake.
- `address_dataOUT`  out  32  address or write data.
- `byte_enablesOUT`  out  4  byte enables.
- `burstSizeOUT`  out  8  burst size.
- `read_n_writeOUT`, `begin_transactionOUT`, `end_transactionOUT`, `data_validOUT`, `busyOUT`  out  1  bus control.
- `address_dataIN`  in  32  read data.
- `end_transactionIN`, `data_validIN`, `busyIN`, `errorIN`  in  1  bus status.

## Operation
- **Bus convention:** all `*OUT` signals are 0 whenever this block is not driving them, because the bus is wire-OR'd.
- **States:** IDLE, REQ, BEGIN, WRITE, WEND, READ, DONE.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the command, load the beat counter with `req_burst`, and go to REQ.
- **REQ:** `bus_request_o`=1. On `bus_grant_i`, go to BEGIN. `bus_request_o` stays high from REQ through WEND/READ.
- **BEGIN (1 cycle):** `begin_transactionOUT`=1 and the address bus carries `req_address`; `byte_enablesOUT`, `burstSizeOUT` and `read_n_writeOUT` (= !write) are driven. Next state is WRITE or READ.
- **WRITE:**
  - Drive `data_validOUT`=`wr_valid` and `address_dataOUT`=`wr_data`.
  - `wr_ready` = !`busyIN`; a beat is accepted when `wr_valid` & !`busyIN`.
  - While `busyIN` is high, data stays held.
  - Each accepted beat decrements the counter. The beat accepted at count 0 moves the FSM to WEND.
- **WEND (1 cycle):** `end_transactionOUT`=1, then go to DONE.
- **READ:**
  - `busyOUT` = !`rd_ready`.
  - A beat is accepted when `data_validIN` & `rd_ready`. It presents `rd_valid`=1 and `rd_data`=`address_dataIN` in the same cycle and decrements the counter.
  - Beats arriving after the counter is exhausted are dropped.
  - `end_transactionIN` moves the FSM to DONE. Error is flagged if fewer than `req_burst`+1 beats were accepted.
- **DONE (1 cycle):** `done_o`=1, `done_error_o`=flag, `bus_request_o`=0. Flag clears, then go to IDLE.
- **Abort:**
  - An `errorIN` seen in BEGIN, WRITE or READ sets the flag.
  - A write goes to WEND, so `end_transactionOUT` is still issued. A read goes straight to DONE.
  - `errorIN` takes priority over a data beat in the same cycle; that beat is not counted.
- **Timeout:**
  - A counter runs in WRITE/READ and resets on every accepted beat.
  - Reaching `TIMEOUT_CYCLES` sets the flag and aborts as for `errorIN`.
  - REQ has no timeout.
- **Simultaneous events:** `end_transactionIN` together with the last read beat accepts the beat and completes without error.

## Timing
- **Reset:** async assertion forces IDLE and clears all outputs to 0, counters to 0 and the flag to 0 immediately, including mid-transfer. `req_ready` rises on the first clock after deassertion.
- **Latency:** request accepted at edge N → `bus_request_o` high in cycle N+1. Grant sampled at edge G → `begin_transactionOUT` high in cycle G+1, for exactly one cycle.
- **Write data path:** first write beat can be accepted in the cycle after BEGIN. Combinational `wr_data`→bus.
- **Single-word write with no stall:** DONE occurs 3 cycles after BEGIN.
- **Read path:** `rd_valid`/`rd_data` are combinational from bus inputs, with zero added latency. `busyOUT` is combinational from `rd_ready`.
- **Widths:** the beat counter is 8 bits and never wraps below 0. The timeout counter is ceil(log2(`TIMEOUT_CYCLES`+1)) bits.

## Test plan
- **Single write:** write 0x0000_1000, be=0xF, burst=0, data 0xDEADBEEF, grant immediate. Expect:
  - `begin_transactionOUT` one cycle with 0x1000 and burstSize 0.
  - Next cycle data 0xDEADBEEF valid.
  - Then `end_transactionOUT`, then `done_o`=1 with `done_error_o`=0.
- **Stalled write:** burst=3 with `busyIN` high for 2 cycles on beat 1. Expect beat 1 held stable for 3 cycles, exactly 4 `wr_ready`&`wr_valid` handshakes, and one end pulse.
- **Backpressured read:** burst=1, slave returns 0xA5A5_0001 and 0xA5A5_0002, `rd_ready` low 1 cycle. Expect `busyOUT` high that cycle, 2 `rd_valid` pulses with the correct data, and done without error.
- **Early read end:** `end_transactionIN` after 1 of 4 beats. Expect `done_error_o`=1.
- **Write error:** `errorIN` during a write beat 2 of 4. Expect the beat not counted, `end_transactionOUT` issued, and done with error.
- **Timeout:** with `TIMEOUT_CYCLES`=8, no read data arrives. Expect done with error 8 cycles after BEGIN exit.
- **Mid-transfer reset:** `system_reset_n` asserted during WRITE. Expect all bus outputs 0 immediately and `req_ready`=1 after release.

Source files
------------

// File: rtl/dbg_bus_master_if.sv
// Shared debug system-bus signals between the bus-master sequencer and
// the wire-OR'd bus fabric / slave side.
interface dbg_bus_master_if;
    logic        bus_request_o;
    logic        bus_grant_i;
    logic [31:0] address_dataOUT;
    logic [3:0]  byte_enablesOUT;
    logic [7:0]  burstSizeOUT;
    logic        read_n_writeOUT;
    logic        begin_transactionOUT;
    logic        end_transactionOUT;
    logic        data_validOUT;
    logic        busyOUT;
    logic [31:0] address_dataIN;
    logic        end_transactionIN;
    logic        data_validIN;
    logic        busyIN;
    logic        errorIN;

    modport master (
        output bus_request_o,
        output address_dataOUT,
        output byte_enablesOUT,
        output burstSizeOUT,
        output read_n_writeOUT,
        output begin_transactionOUT,
        output end_transactionOUT,
        output data_validOUT,
        output busyOUT,
        input  bus_grant_i,
        input  address_dataIN,
        input  end_transactionIN,
        input  data_validIN,
        input  busyIN,
        input  errorIN
    );

    modport slave (
        input  bus_request_o,
        input  address_dataOUT,
        input  byte_enablesOUT,
        input  burstSizeOUT,
        input  read_n_writeOUT,
        input  begin_transactionOUT,
        input  end_transactionOUT,
        input  data_validOUT,
        input  busyOUT,
        output bus_grant_i,
        output address_dataIN,
        output end_transactionIN,
        output data_validIN,
        output busyIN,
        output errorIN
    );
endinterface

// File: rtl/dbg_bus_master.sv
// Debug bus-master sequencer: requests the system bus and runs single or
// burst read/write transfers with flow control, error and timeout abort.
module dbg_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             system_clock,
    input  logic             system_reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_address,
    input  logic [3:0]       req_byte_en,
    input  logic [7:0]       req_burst,
    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             done_o,
    output logic             done_error_o,
    dbg_bus_master_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_BEGIN, S_WRITE, S_WEND, S_READ, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          live_q;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [7:0]    burst_q;
    logic [7:0]    count_q, count_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          last_q, last_d;
    logic          take;
    logic          beat;

    assign take = req_valid && live_q && (state_q == S_IDLE);

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= S_IDLE;
            live_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            burst_q <= '0;
            count_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            last_q  <= last_d;
            if (take) begin
                write_q <= req_write;
                addr_q  <= req_address;
                be_q    <= req_byte_en;
                burst_q <= req_burst;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        last_d  = last_q;
        beat    = 1'b0;

        req_ready    = live_q && (state_q == S_IDLE);
        wr_ready     = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = '0;
        done_o       = 1'b0;
        done_error_o = 1'b0;

        bus.bus_request_o        = 1'b0;
        bus.address_dataOUT      = '0;
        bus.byte_enablesOUT      = '0;
        bus.burstSizeOUT         = '0;
        bus.read_n_writeOUT      = 1'b0;
        bus.begin_transactionOUT = 1'b0;
        bus.end_transactionOUT   = 1'b0;
        bus.data_validOUT        = 1'b0;
        bus.busyOUT              = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_REQ;
                    count_d = req_burst;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_REQ: begin
                bus.bus_request_o = 1'b1;
                if (bus.bus_grant_i) state_d = S_BEGIN;
            end
            S_BEGIN: begin
                bus.bus_request_o        = 1'b1;
                bus.begin_transactionOUT = 1'b1;
                bus.address_dataOUT      = addr_q;
                bus.byte_enablesOUT      = be_q;
                bus.burstSizeOUT         = burst_q;
                bus.read_n_writeOUT      = !write_q;
                tmo_d = '0;
                if (bus.errorIN) begin
                    err_d   = 1'b1;
                    state_d = write_q ? S_WEND : S_DONE;
                end else begin
                    state_d = write_q ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                bus.bus_request_o   = 1'b1;
                bus.data_validOUT   = wr_valid;
                bus.address_dataOUT = wr_data;
                // an erroring cycle must not look like a handshake upstream
                wr_ready = !bus.busyIN && !bus.errorIN;
                beat     = wr_valid && wr_ready;
                if (bus.errorIN) begin
                    err_d   = 1'b1;
                    state_d = S_WEND;
                end else if (beat) begin
                    tmo_d = '0;
                    if (count_q == 8'd0) state_d = S_WEND;
                    else count_d = count_q - 8'd1;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_WEND;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WEND: begin
                bus.bus_request_o      = 1'b1;
                bus.end_transactionOUT = 1'b1;
                state_d = S_DONE;
            end
            S_READ: begin
                bus.bus_request_o = 1'b1;
                bus.busyOUT       = !rd_ready;
                beat = bus.data_validIN && rd_ready
                    && !last_q && !bus.errorIN;
                rd_valid = beat;
                rd_data  = beat ? bus.address_dataIN : '0;
                if (beat) begin
                    tmo_d = '0;
                    if (count_q == 8'd0) last_d = 1'b1;
                    else count_d = count_q - 8'd1;
                end
                if (bus.errorIN) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (bus.end_transactionIN) begin
                    state_d = S_DONE;
                    if (!(last_q || (beat && count_q == 8'd0)))
                        err_d = 1'b1;
                end else if (!beat) begin
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_o       = 1'b1;
                done_error_o = err_q;
                err_d   = 1'b0;
                last_d  = 1'b0;
                tmo_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed self-checking bench for dbg_bus_master (TIMEOUT_CYCLES = 8).
module tb_dbg_bus_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_address;
    logic [3:0]  req_byte_en;
    logic [7:0]  req_burst;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        done_o;
    logic        done_error_o;

    int errors = 0;
    int checks = 0;

    dbg_bus_master_if bus ();

    dbg_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .system_clock   (clk),
        .system_reset_n (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_byte_en    (req_byte_en),
        .req_burst      (req_burst),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .done_o         (done_o),
        .done_error_o   (done_error_o),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic wr, input logic [31:0] a,
                         input logic [7:0] n, input int gdly);
        step();
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = a;
        req_byte_en = 4'hF;
        req_burst   = n;
        #1;
        chk("req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        bus.bus_grant_i = (gdly == 0);
        #1;
        chk("bus_req", bus.bus_request_o, 1);
        for (int i = 0; i < gdly; i++) begin
            step();
            bus.bus_grant_i = (i == gdly - 1);
            #1;
            chk("req_hold", bus.begin_transactionOUT, 0);
        end
        step();
        bus.bus_grant_i = 1'b0;
        #1;
        chk("begin", bus.begin_transactionOUT, 1);
        chk("begin_addr", bus.address_dataOUT, a);
        chk("begin_burst", bus.burstSizeOUT, n);
        chk("begin_be", bus.byte_enablesOUT, 4'hF);
        chk("begin_rnw", bus.read_n_writeOUT, !wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int hs, held, ends, n, stall, idx;
        logic seen;

        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_address = 0;
        req_byte_en = 0; req_burst = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 1'b1;
        bus.bus_grant_i = 0; bus.address_dataIN = 0;
        bus.end_transactionIN = 0; bus.data_validIN = 0;
        bus.busyIN = 0; bus.errorIN = 0;

        // reset state
        step(); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bus_req", bus.bus_request_o, 0);
        chk("rst_addr", bus.address_dataOUT, 0);
        step(); rst_n = 1'b1; #1;
        chk("rel_req_ready", req_ready, 0);
        step(); #1;
        chk("live_req_ready", req_ready, 1);

        // single write
        wr_valid = 1'b1;
        wr_data  = 32'hDEADBEEF;
        issue(1'b1, 32'h0000_1000, 8'd0, 0);
        chk("sw_begin_dv", bus.data_validOUT, 0);
        step(); #1;
        chk("sw_dv", bus.data_validOUT, 1);
        chk("sw_data", bus.address_dataOUT, 32'hDEADBEEF);
        chk("sw_wr_ready", wr_ready, 1);
        chk("sw_begin_low", bus.begin_transactionOUT, 0);
        step(); wr_valid = 1'b0; #1;
        chk("sw_end", bus.end_transactionOUT, 1);
        chk("sw_end_addr", bus.address_dataOUT, 0);
        step(); #1;
        chk("sw_done", done_o, 1);
        chk("sw_done_err", done_error_o, 0);
        chk("sw_done_breq", bus.bus_request_o, 0);
        step(); #1;
        chk("sw_idle_ready", req_ready, 1);
        chk("sw_idle_done", done_o, 0);

        // stalled write, burst of 4, beat 1 stalled 2 cycles
        issue(1'b1, 32'h0000_2000, 8'd3, 0);
        hs = 0; held = 0; ends = 0; n = 0; stall = 0; idx = 0;
        seen = 0;
        for (int c = 1; c <= 16 && !seen; c++) begin
            step();
            wr_valid = (idx < 4);
            wr_data  = 32'h1111_0000 + idx;
            bus.busyIN = (idx == 1 && stall < 2);
            #1;
            if (wr_ready && wr_valid) hs++;
            if (idx == 1 && bus.data_validOUT
                && bus.address_dataOUT == 32'h1111_0001) held++;
            if (bus.end_transactionOUT) ends++;
            if (done_o) begin
                seen = 1;
                n = c;
                chk("stw_done_err", done_error_o, 0);
            end
            if (wr_ready && wr_valid) idx++;
            else if (bus.busyIN) stall++;
        end
        wr_valid = 1'b0;
        bus.busyIN = 1'b0;
        chk("stw_handshakes", hs, 4);
        chk("stw_held", held, 3);
        chk("stw_end_pulses", ends, 1);
        chk("stw_done_cycle", n, 8);

        // backpressured read, burst of 2, delayed grant
        issue(1'b0, 32'h0000_3000, 8'd1, 2);
        step();
        bus.data_validIN = 1'b1;
        bus.address_dataIN = 32'hA5A5_0001;
        rd_ready = 1'b1;
        #1;
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 32'hA5A5_0001);
        chk("rd0_busy", bus.busyOUT, 0);
        step();
        bus.address_dataIN = 32'hA5A5_0002;
        rd_ready = 1'b0;
        #1;
        chk("rd_bp_busy", bus.busyOUT, 1);
        chk("rd_bp_valid", rd_valid, 0);
        step();
        rd_ready = 1'b1;
        bus.end_transactionIN = 1'b1;
        #1;
        chk("rd1_valid", rd_valid, 1);
        chk("rd1_data", rd_data, 32'hA5A5_0002);
        step();
        bus.data_validIN = 1'b0;
        bus.end_transactionIN = 1'b0;
        #1;
        chk("rd_done", done_o, 1);
        chk("rd_done_err", done_error_o, 0);

        // early read end after 1 of 4 beats
        issue(1'b0, 32'h0000_4000, 8'd3, 0);
        step();
        bus.data_validIN = 1'b1;
        bus.address_dataIN = 32'h0BAD_0000;
        #1;
        chk("er_valid", rd_valid, 1);
        step();
        bus.data_validIN = 1'b0;
        bus.end_transactionIN = 1'b1;
        #1;
        chk("er_novalid", rd_valid, 0);
        step();
        bus.end_transactionIN = 1'b0;
        #1;
        chk("er_done", done_o, 1);
        chk("er_done_err", done_error_o, 1);

        // write error on beat 2 of 4
        wr_valid = 1'b1;
        issue(1'b1, 32'h0000_5000, 8'd3, 0);
        step();
        wr_data = 32'h5555_0000;
        #1;
        chk("we_beat0", wr_ready, 1);
        step();
        wr_data = 32'h5555_0001;
        bus.errorIN = 1'b1;
        #1;
        chk("we_beat1_ready", wr_ready, 0);
        step();
        bus.errorIN = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("we_end", bus.end_transactionOUT, 1);
        step(); #1;
        chk("we_done", done_o, 1);
        chk("we_done_err", done_error_o, 1);

        // read timeout, no data ever returned
        issue(1'b0, 32'h0000_6000, 8'd0, 0);
        n = 0; seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            step(); #1;
            if (done_o) begin
                seen = 1;
                n = c;
                chk("tmo_err", done_error_o, 1);
            end
        end
        chk("tmo_cycles", n, 9);

        // reset in the middle of a write
        wr_valid = 1'b1;
        wr_data  = 32'h7777_0000;
        issue(1'b1, 32'h0000_7000, 8'd3, 0);
        step(); #1;
        chk("mr_beat0", wr_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_breq", bus.bus_request_o, 0);
        chk("mr_dv", bus.data_validOUT, 0);
        chk("mr_addr", bus.address_dataOUT, 0);
        chk("mr_wr_ready", wr_ready, 0);
        chk("mr_req_ready", req_ready, 0);
        step();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mr_rel_ready", req_ready, 0);
        step(); #1;
        chk("mr_ready", req_ready, 1);
        chk("mr_idle_breq", bus.bus_request_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
